// File: rtl/mips_muldiv_pkg.sv
`default_nettype none
// mips_muldiv_pkg: op codes, sequencer states and size defaults for the HI/LO muldiv path (rev 1.0)
package mips_muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_iter_core.sv
`default_nettype none
// hilo_iter_core: shared 2*WIDTH accumulator doing one shift-add or restoring-divide step per cycle (rev 1.0)
module hilo_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   init,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc,
  output logic [CNT_W-1:0]     count
);

  logic [WIDTH-1:0]   opnd;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_next;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide:   acc = {partial remainder, dividend/quotient bits}, shifted left.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_next  = acc;
    if (div_mode) begin
      if (div_trial[WIDTH])
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      else
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else if (acc[0]) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      opnd  <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= init;
      opnd  <= operand;
      count <= '0;
    end else if (step) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// hilo_muldiv_ctrl: MIPS HI/LO multiply/divide sequencer, falling-edge clocked (rev 1.0).
// Optional macro HILO_FAST_MUL_EN selects a single-cycle combinational multiply.
module hilo_muldiv_ctrl
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;

  logic               is_mul_op;
  logic               is_div_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               core_load;
  logic               core_step;
  logic [2*WIDTH-1:0] core_init;
  logic [WIDTH-1:0]   core_opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = op_is_signed(op) && rs_val[WIDTH-1];
    b_neg     = op_is_signed(op) && rt_val[WIDTH-1];
    a_mag     = a_neg ? -rs_val : rs_val;
    b_mag     = b_neg ? -rt_val : rt_val;
  end

  // The core always iterates on magnitudes; the sign bits are applied in FIX.
  always_comb begin
    core_init = {{WIDTH{1'b0}}, a_mag};
    core_opnd = b_mag;
    if (is_mul_op) begin
`ifdef HILO_FAST_MUL_EN
      core_init = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
      core_init = {{WIDTH{1'b0}}, b_mag};
`endif
      core_opnd = a_mag;
    end
  end

  assign core_load = (state == IDLE) && start &&
                     (is_mul_op || (is_div_op && (rt_val != '0)));
  assign core_step = (state == MUL) || (state == DIV);

  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  hilo_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .div_mode (is_div),
    .init     (core_init),
    .operand  (core_opnd),
    .acc      (acc),
    .count    (count)
  );

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: begin
                hi   <= rs_val;
                dz   <= 1'b0;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= rs_val;
                dz   <= 1'b0;
                done <= 1'b1;
              end
              OP_MULT, OP_MULTU: begin
                dz     <= 1'b0;
                is_div <= 1'b0;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= 1'b0;
                busy   <= 1'b1;
`ifdef HILO_FAST_MUL_EN
                state  <= FIX;
`else
                state  <= MUL;
`endif
              end
              OP_DIV, OP_DIVU: begin
                if (rt_val == '0) begin
                  dz    <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  dz     <= 1'b0;
                  is_div <= 1'b1;
                  neg_lo <= a_neg ^ b_neg;
                  neg_hi <= a_neg;
                  busy   <= 1'b1;
                  state  <= DIV;
                end
              end
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (count == LAST_STEP)
            state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer for the MIPS-54 multiply/divide path. Owns the HI/LO register pair.
- Accepts one operation at a time from the control unit: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Runs iterative shift-add multiply and restoring divide, then commits HI/LO.
- Asserts busy so the multicycle controller stalls until the result is valid.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- rs_val  in  WIDTH  multiplicand / dividend / MTHI and MTLO source.
- rt_val  in  WIDTH  multiplier / divisor.
- busy  out  1  high from the edge after start is accepted until the commit edge.
- done  out  1  one-cycle pulse on the cycle after HI/LO commit.
- dz  out  1  sticky divide-by-zero flag; cleared by the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, dz=0, state=IDLE, counter=0. Reset mid-operation aborts immediately; partial results are discarded.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start=1:
  - MTHI/MTLO: write hi (or lo) on that edge, pulse done next cycle, stay IDLE, busy never asserts.
  - MULT/MULTU: latch operands. For signed ops, store absolute values and a result-sign bit. Go to MUL, counter=0.
  - DIV/DIVU with rt_val=0: set dz, leave hi/lo unchanged, go to DONE.
  - DIV/DIVU with rt_val≠0: latch absolute values plus quotient-sign and remainder-sign bits (remainder sign = dividend sign). Go to DIV.
  - op 6/7: ignored.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator. After WIDTH steps go to FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After WIDTH steps go to FIX.
- FIX: apply two's-complement negation per the sign bits.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Commit on this edge, then go to DONE.
- DONE: busy=0, done=1 for one cycle, return to IDLE.
- Latency, start edge to commit edge: multiply and divide = WIDTH+1 cycles (33); dz = 1 cycle with no commit. done pulses the following cycle.
- start while busy: ignored, no queuing. The control unit must hold the instruction until done.
- Overflow: -2^31 / -1 gives lo=0x80000000, hi=0. No trap.
- hi/lo stay stable throughout MUL/DIV; there are no intermediate updates.

Optional Feature:
- Macro HILO_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle combinational 64-bit product. The path is IDLE→FIX→DONE, so commit is 1 cycle after start. DIV is unchanged.
- Undefined: iterative 33-cycle multiply as specified above.

Decomposition:
- Shared package mips_muldiv_pkg holds:
  - the op encoding constants (OP_MULT … OP_MTLO);
  - the state enum (IDLE, MUL, DIV, FIX, DONE);
  - WIDTH and CNT_W defaults.
- One natural sub-module: hilo_iter_core. It holds the shared 2*WIDTH accumulator and the counter, performing the shift-add or restoring-divide step selected by a mode bit.
- The controller keeps the FSM, sign handling, HI/LO registers and dz.

Test Plan:
- Reset mid-DIV (assert rst at iteration 10) -> hi=lo=0, busy=0, dz=0 immediately. A fresh DIVU 100/7 afterwards gives lo=14, hi=2.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> 33 cycles later hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high exactly 33 cycles; done one pulse. MULTU with same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=5, rt=0 -> dz=1, hi/lo hold their prior values, done after 1 cycle. The next MTLO 0x1234 clears dz and sets lo=0x1234 with busy never asserted.
- start MULT, then pulse start with DIV at cycle 5 -> second request ignored; final result is the MULT product only.
- With HILO_FAST_MUL_EN defined: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, committed 1 cycle after start.
